tdm_demux: RTL and testbench

- Receiving end of a time-division multiplexed word stream; the select-driven mux of the lab datapath is the sending end.
- A sender serialises N channel words into one W-bit lane, one word per slot, with slot 0 flagged by in_sof.
- This block tracks the slot index, rebuilds the N-word frame in a collection buffer, and hands complete frames to a consumer through a valid/ready output register.
- The input side never stalls.

---
 rtl/tdm_demux.sv | 124 ++++++++++++
 tb/tb_tdm_demux.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux.sv
// Receiver for a TDM word stream: tracks the slot index, rebuilds N-word frames and
// presents them through a valid/ready output register. Optional counters: TDM_DEMUX_STAT_EN.
module tdm_demux #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic           CLK,
  input  logic           RST_X,
  input  logic           in_valid,
  input  logic           in_sof,
  input  logic [W-1:0]   in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_data,
  output logic           busy
`ifdef TDM_DEMUX_STAT_EN
  ,
  output logic [7:0]     drop_cnt,
  output logic [7:0]     sync_err_cnt
`endif
);

  localparam int SW = (N > 2) ? $clog2(N) : 1;
  localparam logic [SW-1:0] LAST = SW'(N - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [SW-1:0] wr_idx;
  logic wr_en;
  logic complete;
  logic resync;
  logic out_free;

  // The last word of a frame bypasses the buffer and goes straight to the output register.
  logic [N-2:0][W-1:0] buf_q;
  logic            out_valid_q;
  logic [N*W-1:0]  out_data_q;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q <= IDLE;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    wr_en    = 1'b0;
    wr_idx   = '0;
    complete = 1'b0;
    resync   = 1'b0;
    if (in_valid) begin
      case (state_q)
        IDLE: begin
          if (in_sof) begin
            wr_en   = 1'b1;
            slot_d  = SW'(1);
            state_d = FILL;
          end
        end
        FILL: begin
          if (in_sof) begin
            resync = 1'b1;
            wr_en  = 1'b1;
            slot_d = SW'(1);
          end else if (slot_q == LAST) begin
            complete = 1'b1;
            slot_d   = '0;
            state_d  = IDLE;
          end else begin
            wr_en  = 1'b1;
            wr_idx = slot_q;
            slot_d = slot_q + SW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A consume on the completing edge frees the register, so frames go back-to-back.
  assign out_free = !out_valid_q || out_ready;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      buf_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      for (int k = 0; k < N - 1; k++) begin
        if (wr_en && wr_idx == SW'(k)) buf_q[k] <= in_data;
      end
      if (complete && out_free) begin
        out_data_q  <= {in_data, buf_q};
        out_valid_q <= 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q == FILL);

`ifdef TDM_DEMUX_STAT_EN
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      drop_cnt     <= '0;
      sync_err_cnt <= '0;
    end else begin
      if (complete && !out_free && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      if (resync && sync_err_cnt != 8'hFF) sync_err_cnt <= sync_err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Directed self-checking bench for tdm_demux (W=8, N=4) with hand-computed frames.
module tb_tdm_demux;

  logic        CLK;
  logic        RST_X;
  logic        in_valid;
  logic        in_sof;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;
`ifdef TDM_DEMUX_STAT_EN
  logic [7:0]  drop_cnt;
  logic [7:0]  sync_err_cnt;
`endif

  int assert_cnt = 0;
  int fail_cnt   = 0;

  tdm_demux #(.W(8), .N(4)) dut (
    .CLK       (CLK),
    .RST_X     (RST_X),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef TDM_DEMUX_STAT_EN
    ,
    .drop_cnt     (drop_cnt),
    .sync_err_cnt (sync_err_cnt)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assert_cnt++;
    if (actual !== expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // One clock edge with the given input word; inputs return idle afterwards.
  task automatic applyStimulus(input logic v, input logic s, input logic [7:0] d);
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic sendFrame(input logic [31:0] f);
    applyStimulus(1'b1, 1'b1, f[7:0]);
    applyStimulus(1'b1, 1'b0, f[15:8]);
    applyStimulus(1'b1, 1'b0, f[23:16]);
    applyStimulus(1'b1, 1'b0, f[31:24]);
  endtask

  initial begin
    RST_X     = 1'b0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;

    // Reset
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("rst_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    RST_X = 1'b1;
    for (int i = 0; i < 10; i++) begin
      idleCycles(1);
      checkOutput("post_rst_valid", 64'(out_valid), 64'd0);
      checkOutput("post_rst_data", 64'(out_data), 64'd0);
      checkOutput("post_rst_busy", 64'(busy), 64'd0);
    end

    // Basic frame, consumer always ready
    applyStimulus(1'b1, 1'b1, 8'h11);
    checkOutput("basic_busy0", 64'(busy), 64'd1);
    checkOutput("basic_nv0", 64'(out_valid), 64'd0);
    applyStimulus(1'b1, 1'b0, 8'h22);
    applyStimulus(1'b1, 1'b0, 8'h33);
    checkOutput("basic_busy2", 64'(busy), 64'd1);
    checkOutput("basic_nv2", 64'(out_valid), 64'd0);
    applyStimulus(1'b1, 1'b0, 8'h44);
    checkOutput("basic_valid", 64'(out_valid), 64'd1);
    checkOutput("basic_data", 64'(out_data), 64'h44332211);
    checkOutput("basic_idle", 64'(busy), 64'd0);
    idleCycles(1);
    checkOutput("basic_one_cycle", 64'(out_valid), 64'd0);
    checkOutput("basic_data_kept", 64'(out_data), 64'h44332211);

    // Gaps between words, consumer stalls for 5 cycles
    out_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 8'h11);
    idleCycles(3);
    applyStimulus(1'b1, 1'b0, 8'h22);
    idleCycles(3);
    checkOutput("gap_busy", 64'(busy), 64'd1);
    checkOutput("gap_nv", 64'(out_valid), 64'd0);
    applyStimulus(1'b1, 1'b0, 8'h33);
    idleCycles(3);
    applyStimulus(1'b1, 1'b0, 8'h44);
    checkOutput("gap_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      idleCycles(1);
      checkOutput("stall_valid", 64'(out_valid), 64'd1);
      checkOutput("stall_data", 64'(out_data), 64'h44332211);
    end
    out_ready = 1'b1;
    idleCycles(1);
    checkOutput("stall_release", 64'(out_valid), 64'd0);

    // Stray word, aborted frame, resync
    applyStimulus(1'b1, 1'b0, 8'h55);
    checkOutput("stray_busy", 64'(busy), 64'd0);
    checkOutput("stray_nv", 64'(out_valid), 64'd0);
    applyStimulus(1'b1, 1'b1, 8'hAA);
    applyStimulus(1'b1, 1'b0, 8'hBB);
    applyStimulus(1'b1, 1'b1, 8'h01);
    checkOutput("resync_busy", 64'(busy), 64'd1);
    applyStimulus(1'b1, 1'b0, 8'h02);
    applyStimulus(1'b1, 1'b0, 8'h03);
    checkOutput("resync_nv", 64'(out_valid), 64'd0);
    applyStimulus(1'b1, 1'b0, 8'h04);
    checkOutput("resync_valid", 64'(out_valid), 64'd1);
    checkOutput("resync_data", 64'(out_data), 64'h04030201);
    idleCycles(1);
    checkOutput("resync_single", 64'(out_valid), 64'd0);
`ifdef TDM_DEMUX_STAT_EN
    checkOutput("sync_err_cnt", 64'(sync_err_cnt), 64'd1);
`endif

    // Overrun, then back-to-back consume and completion
    out_ready = 1'b0;
    sendFrame(32'h04030201);
    checkOutput("f1_valid", 64'(out_valid), 64'd1);
    checkOutput("f1_data", 64'(out_data), 64'h04030201);
    sendFrame(32'h08070605);
    checkOutput("ovr_valid", 64'(out_valid), 64'd1);
    checkOutput("ovr_data", 64'(out_data), 64'h04030201);
`ifdef TDM_DEMUX_STAT_EN
    checkOutput("drop_cnt", 64'(drop_cnt), 64'd1);
`endif
    applyStimulus(1'b1, 1'b1, 8'h09);
    applyStimulus(1'b1, 1'b0, 8'h0A);
    applyStimulus(1'b1, 1'b0, 8'h0B);
    checkOutput("f3_hold", 64'(out_data), 64'h04030201);
    out_ready = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h0C);
    checkOutput("b2b_valid", 64'(out_valid), 64'd1);
    checkOutput("b2b_data", 64'(out_data), 64'h0C0B0A09);
    idleCycles(1);
    checkOutput("b2b_drain", 64'(out_valid), 64'd0);

    // Reset in the middle of a frame
    applyStimulus(1'b1, 1'b1, 8'h11);
    applyStimulus(1'b1, 1'b0, 8'h22);
    RST_X = 1'b0;
    #1;
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_data", 64'(out_data), 64'd0);
    @(posedge CLK);
    #1;
    RST_X = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h33);
    checkOutput("midrst_nv0", 64'(out_valid), 64'd0);
    applyStimulus(1'b1, 1'b0, 8'h44);
    checkOutput("midrst_nv1", 64'(out_valid), 64'd0);
    checkOutput("midrst_busy1", 64'(busy), 64'd0);
    idleCycles(2);
    checkOutput("midrst_nv2", 64'(out_valid), 64'd0);
`ifdef TDM_DEMUX_STAT_EN
    checkOutput("midrst_drop", 64'(drop_cnt), 64'd0);
    checkOutput("midrst_sync", 64'(sync_err_cnt), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
